aes_round_sched: RTL and testbench
==================================

# aes_round_sched

Scheduler that shares one iterative AES round datapath between an encrypt requester and a decrypt requester. It arbitrates, loads the winner's 128-bit block, and steps the core one round per cycle. Each cycle it drives round index, key-word select, and first/last-round flags, sized by key length. It returns the result and a done pulse to the owning requester. It sits between the key-expansion/ready logic and the shared round core that replaces the separate encrypt and decrypt engines.

## Interface
Parameters:
- DATA_W, 128, block width; only 128 is supported.
- IDX_W, 4, width of the key-word index into the `[15:1][127:0]` key_words array.

Ports:
- eph1  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low.
- enc_req_i  in  1  encrypt job request.
- enc_data_i  in  128  plaintext; must be valid while enc_req_i is high.
- enc_gnt_o  out  1  one-cycle pulse: encrypt job accepted.
- enc_done_o  out  1  one-cycle pulse: res_o holds ciphertext.
- dec_req_i  in  1  decrypt job request.
- dec_data_i  in  128  ciphertext; must be valid while dec_req_i is high.
- dec_gnt_o  out  1  one-cycle pulse: decrypt job accepted.
- dec_done_o  out  1  one-cycle pulse: res_o holds plaintext.
- key_size_i  in  2  key size, sampled at grant: 00=128, 01=192, 1x=256.
- rnd_vld_o  out  1  core performs one round this cycle.
- rnd_load_o  out  1  core loads rnd_state_o instead of its feedback register.
- rnd_state_o  out  128  block captured at grant.
- rnd_dec_o  out  1  1 = inverse round.
- rnd_idx_o  out  4  key_words index for this round.
- rnd_first_o  out  1  AddRoundKey-only round.
- rnd_last_o  out  1  final round, no (Inv)MixColumns.
- core_result_i  in  128  core state register output; valid the cycle after a round is issued.
- res_o  out  128  registered result.
- busy_o  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE.
- **IDLE:** if any req is high, arbitrate. Capture the winner's data, key_size_i, and mode; pulse its gnt. Go to LOAD.
- **LOAD:** rnd_vld_o=1, rnd_load_o=1, rnd_first_o=1, round counter r=0. Go to ROUND with r=1.
- **ROUND:** rnd_vld_o=1 for r=1..Nr. rnd_last_o=1 when r==Nr. After r==Nr, go to DONE.
- **DONE:** capture res_o from core_result_i and pulse the owner's done. Go to IDLE.
- Round count Nr: 10, 12, or 14 for key_size 00, 01, or 1x.
- Key-word index:
  - encrypt: rnd_idx_o = 15 − r.
  - decrypt: rnd_idx_o = 15 − Nr + r.
  - For 256-bit keys, encrypt covers index 15→1 and decrypt covers 1→15.
- Counter width is 4 bits; it never wraps because Nr ≤ 14.
- Arbitration with only one requester high: that requester wins.
- Arbitration with both requesters high: resolved per Configuration.
- Requests are sampled only in IDLE. A requester may drop req before its gnt (withdraw) with no effect.
- After gnt, the requester must deassert req the next cycle unless it is presenting a new job. A held req is treated as a new job at the next IDLE.
- In any non-IDLE state, rnd_* outputs hold the values defined for that state. In IDLE they are all 0.
- res_o holds its last value until the next DONE.

## Timing
- Reset value of every output is 0, including res_o and rnd_state_o. Arbitration pointer resets to encrypt.
- Reset asserted mid-job: FSM goes to IDLE at that edge. No done is emitted and the job is lost.
- Latency with req high in IDLE at cycle 0:
  - gnt is high in cycle 1 (LOAD).
  - Rounds run in cycles 1..Nr+1.
  - done and valid res_o appear in cycle Nr+3.
  - For a 128-bit key: done in cycle 13; 192-bit: cycle 15; 256-bit: cycle 17.
- Back-to-back jobs: IDLE is re-entered in the done cycle, so a pending req there is granted the next cycle. Throughput is one job per Nr+3 cycles.
- gnt and done are single-cycle registered pulses. enc_* and dec_* are never high in the same cycle.

## Configuration
- AES_SCHED_RR_EN defined: round-robin arbitration.
  - With both reqs high, the requester not granted last wins.
  - The pointer flips only on a grant.
- AES_SCHED_RR_EN undefined: fixed priority, encrypt always wins.
  - A continuously requesting encryptor starves decrypt; this is accepted.

## Test plan
- **Single encrypt, 256-bit key:** key_size=10, enc_data=128'h27ECB2E3A5EE3894885B5289307400E3.
  - enc_gnt_o in cycle 1.
  - rnd_idx_o runs 15,14,…,1 in cycles 1..15, with rnd_first_o in cycle 1 and rnd_last_o in cycle 15.
  - enc_done_o in cycle 17; res_o equals the core output.
- **Single decrypt, 128-bit key:** key_size=00.
  - rnd_idx_o runs 5,6,…,15 and rnd_dec_o=1 throughout.
  - dec_done_o in cycle 13.
- **Simultaneous requests, both held:**
  - With AES_SCHED_RR_EN: grant order enc, dec, enc, dec.
  - Without it: grant order enc, enc, enc.
- **192-bit key:** Nr=12; rnd_last_o with rnd_idx_o=3 on encrypt; done in cycle 15.
- **Reset mid-job:** reset low during ROUND r=5.
  - Next cycle: busy_o=0, all outputs 0, no done pulse.
  - A new req after reset release completes normally.
- **Withdraw:** enc_req_i high for one cycle while busy, then low; no enc_gnt_o is ever issued.

Source files
------------

// File: rtl/aes_round_sched.sv
// Shares one AES round core between encrypt/decrypt requesters; done Nr+3 cycles after req; no backpressure, a held req is a new job.
// AES_SCHED_RR_EN selects round-robin arbitration, otherwise encrypt has fixed priority.
module aes_round_sched #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 4
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              enc_req_i,
  input  logic [DATA_W-1:0] enc_data_i,
  output logic              enc_gnt_o,
  output logic              enc_done_o,
  input  logic              dec_req_i,
  input  logic [DATA_W-1:0] dec_data_i,
  output logic              dec_gnt_o,
  output logic              dec_done_o,
  input  logic [1:0]        key_size_i,
  output logic              rnd_vld_o,
  output logic              rnd_load_o,
  output logic [DATA_W-1:0] rnd_state_o,
  output logic              rnd_dec_o,
  output logic [IDX_W-1:0]  rnd_idx_o,
  output logic              rnd_first_o,
  output logic              rnd_last_o,
  input  logic [DATA_W-1:0] core_result_i,
  output logic [DATA_W-1:0] res_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  typedef struct packed {
    logic              dec;
    logic [3:0]        nr;
    logic [DATA_W-1:0] blk;
  } job_t;

  state_t            state_q, state_d;
  job_t              job_q;
  logic [3:0]        rnd_q;
  logic              grant, win_dec;
  logic              enc_gnt_q, dec_gnt_q, enc_done_q, dec_done_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        idx_enc, idx_dec;

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      2'b00:   nr_of = 4'd10;
      2'b01:   nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

  assign grant = (state_q == IDLE) && (enc_req_i || dec_req_i);

`ifdef AES_SCHED_RR_EN
  // Points at the requester that wins a tie; moves only when someone is granted.
  logic prio_dec_q;

  always_ff @(posedge eph1) begin
    if (!reset)
      prio_dec_q <= 1'b0;
    else if (grant)
      prio_dec_q <= !win_dec;
  end

  assign win_dec = dec_req_i && (!enc_req_i || prio_dec_q);
`else
  assign win_dec = dec_req_i && !enc_req_i;
`endif

  always_ff @(posedge eph1) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (rnd_q == job_q.nr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      job_q      <= '0;
      rnd_q      <= 4'd0;
      enc_gnt_q  <= 1'b0;
      dec_gnt_q  <= 1'b0;
      enc_done_q <= 1'b0;
      dec_done_q <= 1'b0;
      res_q      <= '0;
    end else begin
      enc_gnt_q  <= grant && !win_dec;
      dec_gnt_q  <= grant && win_dec;
      enc_done_q <= (state_q == DONE) && !job_q.dec;
      dec_done_q <= (state_q == DONE) && job_q.dec;
      if (grant) begin
        job_q.dec <= win_dec;
        job_q.nr  <= nr_of(key_size_i);
        job_q.blk <= win_dec ? dec_data_i : enc_data_i;
      end
      case (state_q)
        LOAD:    rnd_q <= 4'd1;
        ROUND:   rnd_q <= rnd_q + 4'd1;
        default: rnd_q <= 4'd0;
      endcase
      // The core result is valid the cycle after the last round, i.e. in DONE.
      if (state_q == DONE)
        res_q <= core_result_i;
    end
  end

  // Decrypt walks the key schedule upward from the first word it needs.
  assign idx_enc = 4'd15 - rnd_q;
  assign idx_dec = 4'd15 - job_q.nr + rnd_q;

  always_comb begin
    rnd_vld_o   = 1'b0;
    rnd_load_o  = 1'b0;
    rnd_first_o = 1'b0;
    rnd_last_o  = 1'b0;
    rnd_idx_o   = '0;
    rnd_dec_o   = 1'b0;
    rnd_state_o = '0;
    if (state_q != IDLE) begin
      rnd_dec_o   = job_q.dec;
      rnd_state_o = job_q.blk;
    end
    case (state_q)
      LOAD: begin
        rnd_vld_o   = 1'b1;
        rnd_load_o  = 1'b1;
        rnd_first_o = 1'b1;
        rnd_idx_o   = IDX_W'(job_q.dec ? idx_dec : idx_enc);
      end
      ROUND: begin
        rnd_vld_o  = 1'b1;
        rnd_last_o = (rnd_q == job_q.nr);
        rnd_idx_o  = IDX_W'(job_q.dec ? idx_dec : idx_enc);
      end
      default: ;
    endcase
  end

  assign enc_gnt_o  = enc_gnt_q;
  assign dec_gnt_o  = dec_gnt_q;
  assign enc_done_o = enc_done_q;
  assign dec_done_o = dec_done_q;
  assign res_o      = res_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomized bench for aes_round_sched with a toy XOR round core and a cycle-timeline reference model.
module tb_aes_round_sched;

  logic         eph1 = 1'b0;
  logic         reset;
  logic         enc_req_i, dec_req_i;
  logic [127:0] enc_data_i, dec_data_i;
  logic         enc_gnt_o, enc_done_o, dec_gnt_o, dec_done_o;
  logic [1:0]   key_size_i;
  logic         rnd_vld_o, rnd_load_o, rnd_dec_o, rnd_first_o, rnd_last_o;
  logic [127:0] rnd_state_o;
  logic [3:0]   rnd_idx_o;
  logic [127:0] core_result_i;
  logic [127:0] res_o;
  logic         busy_o;

  always #5 eph1 = ~eph1;

  aes_round_sched #(.DATA_W(128), .IDX_W(4)) dut (
    .eph1(eph1), .reset(reset),
    .enc_req_i(enc_req_i), .enc_data_i(enc_data_i), .enc_gnt_o(enc_gnt_o), .enc_done_o(enc_done_o),
    .dec_req_i(dec_req_i), .dec_data_i(dec_data_i), .dec_gnt_o(dec_gnt_o), .dec_done_o(dec_done_o),
    .key_size_i(key_size_i),
    .rnd_vld_o(rnd_vld_o), .rnd_load_o(rnd_load_o), .rnd_state_o(rnd_state_o), .rnd_dec_o(rnd_dec_o),
    .rnd_idx_o(rnd_idx_o), .rnd_first_o(rnd_first_o), .rnd_last_o(rnd_last_o),
    .core_result_i(core_result_i), .res_o(res_o), .busy_o(busy_o)
  );

  // Toy round core: each round XORs in the selected key word.
  logic [127:0] kw [0:15];
  logic [127:0] core_q = '0;
  assign core_result_i = core_q;
  always @(posedge eph1)
    if (rnd_vld_o) core_q <= (rnd_load_o ? rnd_state_o : core_q) ^ kw[rnd_idx_o];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge eph1);
    #1;
  endtask

  function automatic int nr_of(input logic [1:0] ks);
    return (ks == 2'b00) ? 10 : (ks == 2'b01) ? 12 : 14;
  endfunction

  function automatic logic [3:0] idx_of(input bit dec, input int nr, input int r);
    return dec ? 4'(15 - nr + r) : 4'(15 - r);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [13:0] ctl();
    return {enc_gnt_o, dec_gnt_o, enc_done_o, dec_done_o, rnd_vld_o, rnd_load_o,
            rnd_first_o, rnd_last_o, rnd_dec_o, busy_o, rnd_idx_o};
  endfunction

  logic [127:0] last_res;

  // Caller is just past an edge with the DUT idle; that cycle is cycle 0.
  task automatic run_job(input bit dec, input logic [1:0] ks, input logic [127:0] data, input bit withdraw);
    int nr;
    logic [127:0] exp_res;
    logic [13:0] exp, mask;
    bit e_gnt, e_vld, e_first, e_last, e_busy, e_done;
    logic [3:0] e_idx;
    nr = nr_of(ks);
    exp_res = data;
    for (int r = 0; r <= nr; r++) exp_res = exp_res ^ kw[idx_of(dec, nr, r)];
    key_size_i = ks;
    if (dec) begin dec_req_i = 1'b1; dec_data_i = data; end
    else     begin enc_req_i = 1'b1; enc_data_i = data; end
    for (int c = 1; c <= nr + 3; c++) begin
      step();
      if (c == 1) begin
        enc_req_i = 1'b0; dec_req_i = 1'b0;
        enc_data_i = rand128(); dec_data_i = rand128();
        key_size_i = 2'($urandom_range(0, 3));
      end
      if (withdraw && c == 3) begin if (dec) enc_req_i = 1'b1; else dec_req_i = 1'b1; end
      if (withdraw && c == 4) begin enc_req_i = 1'b0; dec_req_i = 1'b0; end
      e_gnt   = (c == 1);
      e_vld   = (c <= nr + 1);
      e_first = (c == 1);
      e_last  = (c == nr + 1);
      e_busy  = (c <= nr + 2);
      e_done  = (c == nr + 3);
      e_idx   = e_vld ? idx_of(dec, nr, c - 1) : 4'd0;
      exp = {e_gnt && !dec, e_gnt && dec, e_done && !dec, e_done && dec, e_vld, e_first,
             e_first, e_last, e_vld && dec, e_busy, e_idx};
      mask = (c == nr + 2) ? 14'b11_1111_1101_0000 : 14'h3fff;
      check($sformatf("ctl d%0d k%0d c%0d", dec, ks, c), ctl() & mask, exp & mask);
      if (c == 1) check("rnd_state", rnd_state_o, data);
      if (c == nr + 3) check($sformatf("res d%0d k%0d", dec, ks), res_o, exp_res);
    end
    last_res = exp_res;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enc_req_i = 1'b0; dec_req_i = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m_prio_dec, exp_dec, found, quiet;
    int cyc, last_gnt;
    for (int i = 0; i < 16; i++) kw[i] = (i == 0) ? '0 : rand128();
    enc_data_i = '0; dec_data_i = '0; key_size_i = 2'b00;
    do_reset();
    check("rst_ctl", ctl(), 14'h0);
    check("rst_res", res_o, '0);
    check("rst_state", rnd_state_o, '0);

    run_job(1'b0, 2'b10, 128'h27ECB2E3A5EE3894885B5289307400E3, 1'b0);
    step(); step(); step();
    check("res_hold", res_o, last_res);
    run_job(1'b1, 2'b00, rand128(), 1'b0);
    run_job(1'b0, 2'b01, rand128(), 1'b0);
    for (int j = 0; j < 12; j++)
      run_job(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand128(), 1'b0);

    // Withdraw: encrypt pulses req mid-job and must never be granted.
    run_job(1'b1, 2'b00, rand128(), 1'b1);
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin step(); if (enc_gnt_o || busy_o) quiet = 1'b0; end
    check("wd_quiet", quiet, 1'b1);

    // Both requesters held continuously.
    do_reset();
    m_prio_dec = 1'b0;
    key_size_i = 2'b00;
    enc_data_i = rand128(); dec_data_i = rand128();
    enc_req_i = 1'b1; dec_req_i = 1'b1;
    cyc = 0; last_gnt = -1;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int t = 0; t < 40; t++) begin
        step(); cyc++;
        if (enc_gnt_o || dec_gnt_o) begin found = 1'b1; break; end
      end
      if (!found) begin check($sformatf("arb_wait%0d", k), 1'b0, 1'b1); break; end
`ifdef AES_SCHED_RR_EN
      exp_dec = m_prio_dec;
`else
      exp_dec = 1'b0;
`endif
      m_prio_dec = !exp_dec;
      check($sformatf("arb_gnt%0d", k), {enc_gnt_o, dec_gnt_o}, exp_dec ? 2'b01 : 2'b10);
      if (last_gnt >= 0) check($sformatf("arb_gap%0d", k), cyc - last_gnt, 13);
      last_gnt = cyc;
    end
    enc_req_i = 1'b0; dec_req_i = 1'b0;
    for (int c = 0; c < 16; c++) step();

    // Reset during round 5 of an encrypt job.
    do_reset();
    key_size_i = 2'b00; enc_data_i = rand128(); enc_req_i = 1'b1;
    step();
    enc_req_i = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    check("mid_idx", rnd_idx_o, 4'd10);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_ctl", ctl(), 14'h0);
    check("mid_rst_res", res_o, '0);
    check("mid_rst_state", rnd_state_o, '0);
    quiet = 1'b1;
    for (int c = 0; c < 16; c++) begin step(); if (enc_done_o || dec_done_o || busy_o) quiet = 1'b0; end
    check("mid_rst_quiet", quiet, 1'b1);
    run_job(1'b0, 2'b00, rand128(), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
